// File: rtl/burst_pkg.sv
// Shared definitions for the word-burst refill protocol: state encoding, burst length
// and line-offset helper. Reused by the burst controller on the other side of the link.
package burst_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StRecv,
        StHold
    } burst_state_e;

    localparam int unsigned BlockSize = 8;
    localparam int unsigned BURST_LEN = BlockSize - 1;

    // Number of byte-address bits that select a position inside one line.
    function automatic int unsigned line_off_bits(input int unsigned block_size,
                                                  input int unsigned data_width);
        return $clog2(block_size * data_width / 8);
    endfunction

endpackage

// File: rtl/refill_line_buffer.sv
// Line assembly storage: BLOCK_SIZE words, one indexed write port, whole line read out flat
// with word 0 in the least significant bits.
module refill_line_buffer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BLOCK_SIZE = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             we_i,
    input  logic [$clog2(BLOCK_SIZE)-1:0]    idx_i,
    input  logic [DATA_WIDTH-1:0]            wdata_i,
    output logic [BLOCK_SIZE*DATA_WIDTH-1:0] line_o
);

    logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] words_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words_q <= '0;
        end else if (we_i) begin
            words_q[idx_i] <= wdata_i;
        end
    end

    assign line_o = words_q;

endmodule

// File: rtl/burst_refill_requester.sv
// Cache-side refill initiator: one burst request per miss, count-based word collection,
// line handed to the cache over valid/ready. Optional BURST_LAST_CHECK_EN enables err.
module burst_refill_requester
    import burst_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BLOCK_SIZE = BlockSize
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             miss_req_i,
    input  logic [ADDR_WIDTH-1:0]            miss_addr_i,
    output logic                             miss_ack_o,
    output logic                             busy_o,
    output logic                             line_valid_o,
    input  logic                             line_ready_i,
    output logic [ADDR_WIDTH-1:0]            line_addr_o,
    output logic [BLOCK_SIZE*DATA_WIDTH-1:0] line_data_o,
    output logic                             mem_req_o,
    output logic [ADDR_WIDTH-1:0]            mem_addr_o,
    output logic [$clog2(BLOCK_SIZE):0]      mem_burst_len_o,
    input  logic                             mem_ready_i,
    input  logic                             mem_valid_i,
    input  logic [DATA_WIDTH-1:0]            mem_data_i,
    input  logic                             mem_last_i,
    output logic                             err_o
);

    localparam int unsigned CntW = $clog2(BLOCK_SIZE);
    localparam int unsigned LenW = CntW + 1;
    localparam int unsigned OffW = line_off_bits(BLOCK_SIZE, DATA_WIDTH);
    localparam logic [CntW-1:0] LastIdx = CntW'(BLOCK_SIZE - 1);
    localparam logic [ADDR_WIDTH-1:0] OffMask = ADDR_WIDTH'((64'd1 << OffW) - 64'd1);

    burst_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0]   line_addr_q, line_addr_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic                    buf_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            line_addr_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            line_addr_q <= line_addr_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        line_addr_d  = line_addr_q;
        cnt_d        = cnt_q;
        miss_ack_o   = 1'b0;
        mem_req_o    = 1'b0;
        line_valid_o = 1'b0;
        buf_we       = 1'b0;
        unique case (state_q)
            StIdle: begin
                miss_ack_o = miss_req_i;
                if (miss_req_i) begin
                    line_addr_d = miss_addr_i & ~OffMask;
                    cnt_d       = '0;
                    state_d     = StReq;
                end
            end
            StReq: begin
                mem_req_o = 1'b1;
                if (mem_ready_i) begin
                    state_d = StRecv;
                end
            end
            StRecv: begin
                if (mem_valid_i) begin
                    buf_we = 1'b1;
                    // Burst ends on the word count alone; the counter never wraps.
                    if (cnt_q == LastIdx) begin
                        state_d = StHold;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StHold: begin
                line_valid_o = 1'b1;
                if (line_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    refill_line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .BLOCK_SIZE (BLOCK_SIZE)
    ) u_line_buffer (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (buf_we),
        .idx_i   (cnt_q),
        .wdata_i (mem_data_i),
        .line_o  (line_data_o)
    );

    assign busy_o          = (state_q != StIdle);
    assign line_addr_o     = line_addr_q;
    assign mem_addr_o      = line_addr_q;
    assign mem_burst_len_o = LenW'(BLOCK_SIZE - 1);

`ifdef BURST_LAST_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (state_q == StIdle && miss_req_i) begin
            err_d = 1'b0;
        end else if (state_q == StRecv && mem_valid_i &&
                     (mem_last_i != (cnt_q == LastIdx))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    logic unused_mem_last;
    assign unused_mem_last = mem_last_i;
    assign err_o           = 1'b0;
`endif

endmodule
